// File: rtl/ddr5_phy_read_window_sched_if.sv
// Read-scheduler bus: decoded READ + mode settings in, capture windows and error pulses out.
// master = decoder/consumer side, slave = scheduler.
interface ddr5_phy_read_window_sched_if #(
  parameter int pNUM_RANK = 1,
  parameter int pRL_W     = 7
);
  logic                 enable_i;
  logic                 rd_cmd_i;
  logic [pNUM_RANK-1:0] rd_cs_i;
  logic [pRL_W-1:0]     read_latency_i;
  logic [1:0]           burst_length_i;
  logic [2:0]           num_pre_cycle_i;
  logic                 num_post_cycle_i;
  logic                 dram_crc_en_i;
  logic                 dqs_rd_en_o;
  logic                 preamble_o;
  logic                 dq_rd_en_o;
  logic                 crc_beat_o;
  logic                 last_beat_o;
  logic                 postamble_o;
  logic [pNUM_RANK-1:0] rd_rank_o;
  logic                 busy_o;
  logic                 ovf_err_o;
  logic                 lat_err_o;
  logic                 conflict_err_o;

  modport master (
    output enable_i, rd_cmd_i, rd_cs_i, read_latency_i, burst_length_i,
           num_pre_cycle_i, num_post_cycle_i, dram_crc_en_i,
    input  dqs_rd_en_o, preamble_o, dq_rd_en_o, crc_beat_o, last_beat_o,
           postamble_o, rd_rank_o, busy_o, ovf_err_o, lat_err_o, conflict_err_o
  );

  modport slave (
    input  enable_i, rd_cmd_i, rd_cs_i, read_latency_i, burst_length_i,
           num_pre_cycle_i, num_post_cycle_i, dram_crc_en_i,
    output dqs_rd_en_o, preamble_o, dq_rd_en_o, crc_beat_o, last_beat_o,
           postamble_o, rd_rank_o, busy_o, ovf_err_o, lat_err_o, conflict_err_o
  );
endinterface

// File: rtl/ddr5_phy_read_window_sched.sv
// Read-window scheduler: queues decoded READs and plays out preamble/data/postamble windows RL clocks later.
// Outputs registered; no backpressure -- full queue, too-short RL or overlapping windows drop the READ with an error pulse.
module ddr5_phy_read_window_sched #(
  parameter int pNUM_RANK = 1,
  parameter int pDEPTH    = 4,
  parameter int pRL_W     = 7,
  parameter int pTS_W     = 8
) (
  input logic                          clk_i,
  input logic                          rst_i,
  ddr5_phy_read_window_sched_if.slave  bus
);

  localparam int PTR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

  typedef struct packed {
    logic [pTS_W-1:0]     data_start;
    logic [pTS_W-1:0]     pre_start;
    logic [pNUM_RANK-1:0] rank;
    logic [4:0]           d;
    logic [2:0]           p;
    logic [1:0]           q;
    logic                 crc;
  } entry_t;

  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

  entry_t               q_mem [pDEPTH];
  entry_t               head;
  entry_t               new_ent;
  logic [PTR_W:0]       wr_ptr, rd_ptr, q_cnt, nxt_q_cnt;
  logic [pTS_W-1:0]     ts, ts_nxt, cur_end;
  state_t               state, nxt_state;
  logic [4:0]           cnt, nxt_cnt, cur_d, dec_d;
  logic [2:0]           dec_p;
  logic [1:0]           dec_q, cur_q;
  logic                 cur_crc, nxt_crc;
  logic [pNUM_RANK-1:0] cur_rank, nxt_rank;
  logic                 q_empty, q_full, push_req, lat_bad, push, pop, load;
  logic                 head_pre_hit, free_next, seam_cand, start, seamless, conflict;

  assign ts_nxt  = ts + pTS_W'(1);
  assign q_cnt   = wr_ptr - rd_ptr;
  assign q_empty = (q_cnt == '0);
  assign head    = q_mem[rd_ptr[PTR_W-1:0]];

  always_comb begin
    unique case (bus.burst_length_i)
      2'b00:   dec_d = 5'd8;
      2'b01:   dec_d = 5'd4;
      default: dec_d = 5'd16;
    endcase
    dec_d = dec_d + {4'b0, bus.dram_crc_en_i};
    unique case (bus.num_pre_cycle_i)
      3'b001, 3'b010: dec_p = 3'd2;
      3'b011:         dec_p = 3'd3;
      3'b100:         dec_p = 3'd4;
      default:        dec_p = 3'd1;
    endcase
    dec_q = bus.num_post_cycle_i ? 2'd2 : 2'd1;
  end

  // Settings are captured here so later mode-register writes cannot disturb a queued burst.
  always_comb begin
    new_ent            = '0;
    new_ent.data_start = ts + pTS_W'(bus.read_latency_i);
    new_ent.pre_start  = new_ent.data_start - pTS_W'(dec_p);
    new_ent.rank       = bus.rd_cs_i;
    new_ent.d          = dec_d;
    new_ent.p          = dec_p;
    new_ent.q          = dec_q;
    new_ent.crc        = bus.dram_crc_en_i;
  end

  // Decisions look one cycle ahead (ts+1) so the registered outputs land on the exact window cycles.
  // A head whose data follows the current burst back-to-back is held until the last data beat.
  assign head_pre_hit = !q_empty && (head.pre_start == ts_nxt);
  assign free_next    = (state == IDLE) || (state == POST && cnt == 5'd1);
  assign seam_cand    = (state == PRE || state == DATA) && (head.data_start == cur_end);
  assign start        = head_pre_hit && free_next;
  assign conflict     = head_pre_hit && !free_next && !seam_cand;
  assign seamless     = !q_empty && (state == DATA) && (cnt == 5'd1) && (head.data_start == ts_nxt);
  assign pop          = start || conflict || seamless;

  assign push_req  = bus.rd_cmd_i && bus.enable_i;
  assign lat_bad   = bus.read_latency_i < (pRL_W'(dec_p) + pRL_W'(2));
  assign q_full    = (q_cnt == (PTR_W+1)'(pDEPTH)) && !pop;
  assign push      = push_req && !q_full && !lat_bad;
  assign nxt_q_cnt = q_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        nxt_state = PRE;
        nxt_cnt   = {2'b0, head.p};
        load      = 1'b1;
      end
      PRE: if (cnt == 5'd1) begin
        nxt_state = DATA;
        nxt_cnt   = cur_d;
      end else nxt_cnt = cnt - 5'd1;
      DATA: if (cnt == 5'd1) begin
        if (seamless) begin
          nxt_cnt = head.d;
          load    = 1'b1;
        end else begin
          nxt_state = POST;
          nxt_cnt   = {3'b0, cur_q};
        end
      end else nxt_cnt = cnt - 5'd1;
      POST: if (cnt == 5'd1) begin
        if (start) begin
          nxt_state = PRE;
          nxt_cnt   = {2'b0, head.p};
          load      = 1'b1;
        end else nxt_state = IDLE;
      end else nxt_cnt = cnt - 5'd1;
      default: nxt_state = IDLE;
    endcase
  end

  assign nxt_rank = load ? head.rank : cur_rank;
  assign nxt_crc  = load ? head.crc  : cur_crc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts                 <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      state              <= IDLE;
      cnt                <= '0;
      cur_d              <= '0;
      cur_q              <= '0;
      cur_crc            <= 1'b0;
      cur_rank           <= '1;
      cur_end            <= '0;
      bus.dqs_rd_en_o    <= 1'b0;
      bus.preamble_o     <= 1'b0;
      bus.dq_rd_en_o     <= 1'b0;
      bus.crc_beat_o     <= 1'b0;
      bus.last_beat_o    <= 1'b0;
      bus.postamble_o    <= 1'b0;
      bus.rd_rank_o      <= '1;
      bus.busy_o         <= 1'b0;
      bus.ovf_err_o      <= 1'b0;
      bus.lat_err_o      <= 1'b0;
      bus.conflict_err_o <= 1'b0;
    end else begin
      ts <= ts_nxt;
      if (push) begin
        q_mem[wr_ptr[PTR_W-1:0]] <= new_ent;
        wr_ptr                   <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (load) begin
        cur_d    <= head.d;
        cur_q    <= head.q;
        cur_crc  <= head.crc;
        cur_rank <= head.rank;
        cur_end  <= head.data_start + pTS_W'(head.d);
      end
      bus.dqs_rd_en_o    <= (nxt_state != IDLE);
      bus.preamble_o     <= (nxt_state == PRE);
      bus.dq_rd_en_o     <= (nxt_state == DATA);
      bus.last_beat_o    <= (nxt_state == DATA) && (nxt_cnt == 5'd1);
      bus.crc_beat_o     <= (nxt_state == DATA) && (nxt_cnt == 5'd1) && nxt_crc;
      bus.postamble_o    <= (nxt_state == POST);
      bus.rd_rank_o      <= (nxt_state != IDLE) ? nxt_rank : '1;
      bus.busy_o         <= (nxt_q_cnt != '0) || (nxt_state != IDLE);
      bus.ovf_err_o      <= push_req && q_full;
      bus.lat_err_o      <= push_req && !q_full && lat_bad;
      bus.conflict_err_o <= conflict;
    end
  end

endmodule

// File: tb/tb_ddr5_phy_read_window_sched.sv
// Directed bench for the read-window scheduler: window timing, seamless, conflict, overflow, latency, reset, MRW, wrap.
// Stimulus and sampling happen on the falling edge; k counts cycles after the READ cycle T.
module tb_ddr5_phy_read_window_sched;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ddr5_phy_read_window_sched_if #(.pNUM_RANK(NR), .pRL_W(7)) bus ();

  ddr5_phy_read_window_sched #(.pNUM_RANK(NR), .pDEPTH(4), .pRL_W(7), .pTS_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [11:0] obs();
    return {bus.dqs_rd_en_o, bus.preamble_o, bus.dq_rd_en_o, bus.crc_beat_o, bus.last_beat_o,
            bus.postamble_o, bus.busy_o, bus.ovf_err_o, bus.lat_err_o, bus.conflict_err_o, bus.rd_rank_o};
  endfunction

  function automatic logic [11:0] mk(input logic pre, input logic dq, input logic crc, input logic last,
                                     input logic post, input logic busy, input logic ovf, input logic lat,
                                     input logic conf, input logic [1:0] rk);
    logic dqs;
    dqs = pre | dq | post;
    return {dqs, pre, dq, crc, last, post, busy, ovf, lat, conf, (dqs ? rk : 2'b11)};
  endfunction

  task automatic set_mr(input logic [1:0] bl, input logic [2:0] pre, input logic post, input logic crc);
    bus.burst_length_i   = bl;
    bus.num_pre_cycle_i  = pre;
    bus.num_post_cycle_i = post;
    bus.dram_crc_en_i    = crc;
  endtask

  // Drives a READ for cycle T and returns at the falling edge of T+1.
  task automatic issue(input logic [6:0] rl, input logic [1:0] cs);
    bus.rd_cmd_i       = 1'b1;
    bus.read_latency_i = rl;
    bus.rd_cs_i        = cs;
    @(negedge clk);
    bus.rd_cmd_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
    if (obs() !== e) begin bad++; $display("FAIL reset_held got=%b want=%b", obs(), e); end
    total++;
    rst = 1'b0;
    @(negedge clk);
    if (obs() !== e) begin bad++; $display("FAIL reset_release got=%b want=%b", obs(), e); end
    total++;
  endtask

  task automatic test_basic();
    logic [11:0] e;
    set_mr(2'b00, 3'b000, 1'b0, 1'b0);
    issue(7'd20, 2'b10);
    for (int k = 1; k <= 31; k++) begin
      e = mk(k == 19, k >= 20 && k <= 27, 0, k == 27, k == 28, k <= 28, 0, 0, 0, 2'b10);
      if (obs() !== e) begin bad++; $display("FAIL basic k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      @(negedge clk);
    end
  endtask

  task automatic test_crc();
    logic [11:0] e;
    set_mr(2'b10, 3'b100, 1'b1, 1'b1);
    issue(7'd20, 2'b01);
    for (int k = 1; k <= 41; k++) begin
      e = mk(k >= 16 && k <= 19, k >= 20 && k <= 36, k == 36, k == 36, k == 37 || k == 38,
             k <= 38, 0, 0, 0, 2'b01);
      if (obs() !== e) begin bad++; $display("FAIL crc k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    set_mr(2'b00, 3'b000, 1'b0, 1'b0);
    issue(7'd20, 2'b10);
    for (int k = 1; k <= 39; k++) begin
      e = mk(k == 19, k >= 20 && k <= 35, 0, k == 27 || k == 35, k == 36, k <= 36, 0, 0, 0,
             (k <= 27) ? 2'b10 : 2'b01);
      if (obs() !== e) begin bad++; $display("FAIL back_to_back k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      bus.rd_cmd_i = (k == 8);
      bus.rd_cs_i  = 2'b01;
      @(negedge clk);
    end
  endtask

  task automatic test_conflict();
    logic [11:0] e;
    set_mr(2'b10, 3'b000, 1'b0, 1'b0);
    issue(7'd20, 2'b10);
    for (int k = 1; k <= 40; k++) begin
      e = mk(k == 19, k >= 20 && k <= 35, 0, k == 35, k == 36, k <= 36, 0, 0, k == 23, 2'b10);
      if (obs() !== e) begin bad++; $display("FAIL conflict k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      bus.rd_cmd_i = (k == 4);
      bus.rd_cs_i  = 2'b01;
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] e;
    set_mr(2'b00, 3'b000, 1'b0, 1'b0);
    issue(7'd60, 2'b10);
    for (int k = 1; k <= 95; k++) begin
      e = mk(k == 59, k >= 60 && k <= 91, 0, k == 67 || k == 75 || k == 83 || k == 91, k == 92,
             k <= 92, k == 33, 0, 0, 2'b10);
      if (obs() !== e) begin bad++; $display("FAIL overflow k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      bus.rd_cmd_i = (k % 8 == 0) && (k <= 32);
      @(negedge clk);
    end
  endtask

  task automatic test_latency();
    logic [11:0] e;
    set_mr(2'b00, 3'b011, 1'b0, 1'b0);
    issue(7'd2, 2'b10);
    for (int k = 1; k <= 4; k++) begin
      e = mk(0, 0, 0, 0, 0, 0, 0, k == 1, 0, 2'b11);
      if (obs() !== e) begin bad++; $display("FAIL lat_short k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      @(negedge clk);
    end
    bus.enable_i = 1'b0;
    issue(7'd20, 2'b10);
    for (int k = 1; k <= 25; k++) begin
      e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
      if (obs() !== e) begin bad++; $display("FAIL disabled k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      @(negedge clk);
    end
    bus.enable_i = 1'b1;
    issue(7'd5, 2'b01);
    for (int k = 1; k <= 15; k++) begin
      e = mk(k >= 2 && k <= 4, k >= 5 && k <= 12, 0, k == 12, k == 13, k <= 13, 0, 0, 0, 2'b01);
      if (obs() !== e) begin bad++; $display("FAIL lat_min k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      @(negedge clk);
    end
  endtask

  task automatic test_mrw();
    logic [11:0] e;
    set_mr(2'b00, 3'b000, 1'b0, 1'b0);
    issue(7'd20, 2'b01);
    set_mr(2'b10, 3'b100, 1'b1, 1'b1);
    bus.read_latency_i = 7'd5;
    for (int k = 1; k <= 31; k++) begin
      e = mk(k == 19, k >= 20 && k <= 27, 0, k == 27, k == 28, k <= 28, 0, 0, 0, 2'b01);
      if (obs() !== e) begin bad++; $display("FAIL mrw k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    set_mr(2'b00, 3'b000, 1'b0, 1'b0);
    issue(7'd20, 2'b10);
    for (int k = 1; k <= 30; k++) begin
      if (k < 23) e = mk(k == 19, k >= 20, 0, 0, 0, 1, 0, 0, 0, 2'b10);
      else        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
      if (k >= 19) begin
        if (obs() !== e) begin bad++; $display("FAIL reset_mid k=%0d got=%b want=%b", k, obs(), e); end
        total++;
      end
      if (k == 22) rst = 1'b1;
      if (k == 23) rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (240) @(negedge clk);
    set_mr(2'b00, 3'b100, 1'b0, 1'b0);
    issue(7'd20, 2'b01);
    for (int k = 1; k <= 31; k++) begin
      e = mk(k >= 16 && k <= 19, k >= 20 && k <= 27, 0, k == 27, k == 28, k <= 28, 0, 0, 0, 2'b01);
      if (obs() !== e) begin bad++; $display("FAIL wrap k=%0d got=%b want=%b", k, obs(), e); end
      total++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    bus.enable_i         = 1'b1;
    bus.rd_cmd_i         = 1'b0;
    bus.rd_cs_i          = 2'b11;
    bus.read_latency_i   = 7'd0;
    bus.burst_length_i   = 2'b00;
    bus.num_pre_cycle_i  = 3'b000;
    bus.num_post_cycle_i = 1'b0;
    bus.dram_crc_en_i    = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    repeat (3) @(negedge clk);
    test_basic();
    repeat (3) @(negedge clk);
    test_crc();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_conflict();
    repeat (3) @(negedge clk);
    test_overflow();
    repeat (3) @(negedge clk);
    test_latency();
    repeat (3) @(negedge clk);
    test_mrw();
    repeat (3) @(negedge clk);
    test_reset_mid();
    repeat (3) @(negedge clk);
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
